txdma_seq: RTL and testbench

Parametrised transmit-DMA frame sequencer between the port command layer and the data-handler/link layer. It splits a command transfer into frames of at most C_FRM_SIZE bytes and requests each frame from the data handler. It then collects per-frame link status from the control stream. Over the previous single-shot sequencer it adds retransmission on R_ERR, a status-wait timeout, host abort, configurable widths and a frame counter.

---
 rtl/txdma_seq_if.sv | 41 ++++
 rtl/txdma_seq.sv | 175 +++++++++++++++++
 tb/tb_txdma_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txdma_seq_if.sv
// txdma_seq_if: port-command, data-handler and control-stream signals
// of the transmit-DMA frame sequencer.
interface txdma_seq_if #(
  parameter int C_LEN_WIDTH = 32,
  parameter int C_FRM_WIDTH = 14
);
  logic                   port2txdma_req;
  logic [C_LEN_WIDTH-1:0] port2txdma_len;
  logic                   port2txdma_abort;
  logic                   txdma2port_ack;
  logic [31:0]            txdma2port_sts;
  logic                   txdma2port_idle;
  logic [15:0]            txdma2port_frm_cnt;
  logic                   tx2dh_req;
  logic [C_FRM_WIDTH-1:0] tx2dh_len;
  logic                   dh2tx_ack;
  logic                   dh2tx_err;
  logic                   ctrl_src_rdy_n;
  logic [31:0]            ctrl_data;
  logic                   ctrl_dst_rdy;
  logic                   txdma2txll_push;
  logic [31:0]            txdma2dbg;

  modport slave (
    input  port2txdma_req, port2txdma_len, port2txdma_abort,
    input  dh2tx_ack, dh2tx_err,
    input  ctrl_src_rdy_n, ctrl_data, txdma2txll_push,
    output txdma2port_ack, txdma2port_sts, txdma2port_idle,
    output txdma2port_frm_cnt, tx2dh_req, tx2dh_len,
    output ctrl_dst_rdy, txdma2dbg
  );

  modport master (
    output port2txdma_req, port2txdma_len, port2txdma_abort,
    output dh2tx_ack, dh2tx_err,
    output ctrl_src_rdy_n, ctrl_data, txdma2txll_push,
    input  txdma2port_ack, txdma2port_sts, txdma2port_idle,
    input  txdma2port_frm_cnt, tx2dh_req, tx2dh_len,
    input  ctrl_dst_rdy, txdma2dbg
  );
endinterface

// File: rtl/txdma_seq.sv
// txdma_seq: splits a transfer into frames, requests each from the data
// handler, collects link status with retry, timeout and abort.
module txdma_seq #(
  parameter int          C_LEN_WIDTH  = 32,
  parameter int          C_FRM_WIDTH  = 14,
  parameter int          C_FRM_SIZE   = 8192,
  parameter int          C_ZERO_LEN   = 8192,
  parameter int          C_MAX_RETRY  = 3,
  parameter int          C_TMO_WIDTH  = 16,
  parameter int          C_TMO_CYCLES = 50000,
  parameter logic [31:0] C_R_OK       = 32'h0000_0001,
  parameter logic [31:0] C_R_ERR      = 32'h0000_0002,
  parameter logic [31:0] C_STS_TMO    = 32'h8000_0001,
  parameter logic [31:0] C_STS_ABORT  = 32'h8000_0002,
  parameter logic [31:0] C_STS_DH_ERR = 32'h8000_0003
) (
  input logic        sys_clk,
  input logic        sys_rst_n,
  txdma_seq_if.slave io
);
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_REQ   = 4'd1,
    S_DATA  = 4'd2,
    S_STS   = 4'd3,
    S_RETRY = 4'd4,
    S_DONE  = 4'd5
  } state_e;

  localparam logic [C_LEN_WIDTH-1:0] FRM_MAX =
    C_LEN_WIDTH'(C_FRM_SIZE);
  localparam logic [C_LEN_WIDTH-1:0] ZERO_LEN =
    C_LEN_WIDTH'(C_ZERO_LEN);
  localparam logic [3:0] MAX_RTY = 4'(C_MAX_RETRY);
  localparam logic [C_TMO_WIDTH-1:0] TMO_LAST =
    C_TMO_WIDTH'(C_TMO_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [C_LEN_WIDTH-1:0] rem_q, rem_d;
  logic [C_FRM_WIDTH-1:0] len_q, len_d;
  logic                   last_q, last_d;
  logic                   errf_q, errf_d;
  logic                   empty_q, empty_d;
  logic [3:0]             rty_q, rty_d;
  logic [C_TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic [31:0]            sts_q, sts_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   dhreq_q, dhreq_d;
  logic                   dst_q, dst_d;
  logic                   busy;

  assign busy = state_q inside {S_REQ, S_DATA, S_STS, S_RETRY};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_d   = len_q;
    last_d  = last_q;
    errf_d  = errf_q;
    empty_d = empty_q;
    rty_d   = rty_q;
    tmo_d   = '0;
    sts_d   = sts_q;
    cnt_d   = cnt_q;
    dhreq_d = 1'b0;
    dst_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rem_d  = (io.port2txdma_len == '0) ? ZERO_LEN
                                           : io.port2txdma_len;
        cnt_d  = '0;
        rty_d  = '0;
        errf_d = 1'b0;
        if (io.port2txdma_req) state_d = S_REQ;
      end
      S_REQ: begin
        last_d  = (rem_q <= FRM_MAX);
        len_d   = last_d ? rem_q[C_FRM_WIDTH-1:0]
                         : FRM_MAX[C_FRM_WIDTH-1:0];
        state_d = S_DATA;
      end
      S_DATA: begin
        dhreq_d = ~(io.dh2tx_ack | io.dh2tx_err);
        if (io.dh2tx_err) begin
          if (empty_q) begin
            sts_d   = C_STS_DH_ERR;
            state_d = S_DONE;
          end else begin
            errf_d  = 1'b1;
            state_d = S_STS;
          end
        end else if (io.dh2tx_ack) begin
          state_d = S_STS;
        end
      end
      S_STS: begin
        tmo_d = tmo_q + 1'b1;
        if (!io.ctrl_src_rdy_n) begin
          dst_d   = 1'b1;
          sts_d   = io.ctrl_data;
          state_d = S_DONE;
          if (io.ctrl_data == C_R_OK) begin
            rem_d = rem_q - C_LEN_WIDTH'(len_q);
            cnt_d = cnt_q + 16'd1;
            rty_d = '0;
            if (!(last_q || errf_q)) state_d = S_REQ;
          end else if (io.ctrl_data == C_R_ERR &&
                       rty_q < MAX_RTY && !errf_q) begin
            rty_d   = rty_q + 4'd1;
            state_d = S_RETRY;
          end
        end else if (C_TMO_CYCLES != 0 && tmo_q == TMO_LAST) begin
          sts_d   = C_STS_TMO;
          state_d = S_DONE;
        end
      end
      S_RETRY: state_d = S_DATA;
      S_DONE:  if (!io.port2txdma_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort freezes the transfer bookkeeping and overrides any transition
    if (io.port2txdma_abort && busy) begin
      state_d = S_DONE;
      sts_d   = C_STS_ABORT;
      dhreq_d = 1'b0;
      dst_d   = 1'b0;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      rty_d   = rty_q;
      errf_d  = errf_q;
    end
    if (state_q inside {S_IDLE, S_RETRY, S_STS}) empty_d = 1'b1;
    if (io.txdma2txll_push) empty_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      errf_q  <= 1'b0;
      empty_q <= 1'b1;
      rty_q   <= '0;
      tmo_q   <= '0;
      sts_q   <= '0;
      cnt_q   <= '0;
      dhreq_q <= 1'b0;
      dst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      last_q  <= last_d;
      errf_q  <= errf_d;
      empty_q <= empty_d;
      rty_q   <= rty_d;
      tmo_q   <= tmo_d;
      sts_q   <= sts_d;
      cnt_q   <= cnt_d;
      dhreq_q <= dhreq_d;
      dst_q   <= dst_d;
    end
  end

  assign io.txdma2port_ack     = (state_q == S_DONE);
  assign io.txdma2port_idle    = (state_q == S_IDLE);
  assign io.txdma2port_sts     = sts_q;
  assign io.txdma2port_frm_cnt = cnt_q;
  assign io.tx2dh_req          = dhreq_q;
  assign io.tx2dh_len          = len_q;
  assign io.ctrl_dst_rdy       = dst_q;
  assign io.txdma2dbg = {16'(len_q), 5'd0, empty_q, errf_q,
                         last_q, rty_q, state_q};
endmodule

// File: tb/tb_txdma_seq.sv
// tb_txdma_seq: randomized transfers against a frame-level model of the
// sequencer, plus directed retry, error, timeout, abort and reset cases.
module tb_txdma_seq;
  localparam int FRM = 8192;
  localparam int MAXR = 3;
  localparam logic [31:0] R_OK = 32'h0000_0001;
  localparam logic [31:0] R_ERR = 32'h0000_0002;
  localparam logic [31:0] S_TMO = 32'h8000_0001;
  localparam logic [31:0] S_ABT = 32'h8000_0002;
  localparam logic [31:0] S_DHE = 32'h8000_0003;
  localparam int DK_ACK = 0, DK_NP = 1, DK_EP = 2;
  localparam int SK_OK = 0, SK_ERR = 1, SK_OTH = 2, SK_TMO = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int dst_tot = 0;
  bit bail = 0;
  int dh_q[$];
  int st_q[$];

  txdma_seq_if #(.C_LEN_WIDTH(32), .C_FRM_WIDTH(14)) u ();

  txdma_seq #(.C_TMO_CYCLES(16)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .io(u.slave)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (u.ctrl_dst_rdy) dst_tot <= dst_tot + 1;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic recover();
    u.port2txdma_req = 0;
    u.port2txdma_abort = 0;
    u.dh2tx_ack = 0;
    u.dh2tx_err = 0;
    u.ctrl_src_rdy_n = 1;
    u.txdma2txll_push = 0;
    sys_rst_n = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    @(negedge sys_clk);
    bail = 0;
  endtask

  task automatic do_dh(input int flen, input int dk);
    int n = 0;
    while (!u.tx2dh_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n == 50) begin
      errors++;
      $display("FAIL dh_req_wait got timeout exp tx2dh_req");
      bail = 1;
      return;
    end
    checks++;
    if (u.tx2dh_len !== 14'(flen)) begin
      errors++;
      $display("FAIL frame_len got %h exp %h", u.tx2dh_len, flen);
    end
    if (dk != DK_NP) begin
      u.txdma2txll_push = 1;
      @(negedge sys_clk);
      u.txdma2txll_push = 0;
    end
    if (dk == DK_ACK) u.dh2tx_ack = 1;
    else u.dh2tx_err = 1;
    @(negedge sys_clk);
    u.dh2tx_ack = 0;
    u.dh2tx_err = 0;
    checks++;
    if (u.tx2dh_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop got %b exp 0", u.tx2dh_req);
    end
  endtask

  task automatic do_sts(input int sk, input logic [31:0] word);
    int n = 0;
    if (sk == SK_TMO) return;
    repeat ($urandom % 4) @(negedge sys_clk);
    u.ctrl_src_rdy_n = 0;
    u.ctrl_data = word;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!u.ctrl_dst_rdy && n < 20);
    u.ctrl_src_rdy_n = 1;
    u.ctrl_data = $urandom;
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL dst_rdy_wait got timeout exp pulse");
      bail = 1;
    end
  endtask

  task automatic run_xfer(input logic [31:0] len);
    int rem, flen, frm, retry, nw, dk, sk, r, n, d0;
    bit last, errf, done;
    logic [31:0] sexp, word;
    rem = (len == 0) ? FRM : int'(len);
    frm = 0; retry = 0; nw = 0; errf = 0; done = 0;
    sexp = 0;
    d0 = dst_tot;
    u.port2txdma_len = len;
    u.port2txdma_req = 1;
    while (!done && !bail) begin
      flen = (rem < FRM) ? rem : FRM;
      last = (rem <= FRM);
      if (dh_q.size() > 0) dk = dh_q.pop_front();
      else begin
        r = $urandom % 100;
        dk = (r < 86) ? DK_ACK : (r < 93) ? DK_NP : DK_EP;
      end
      do_dh(flen, dk);
      if (bail) break;
      if (dk == DK_NP) begin
        sexp = S_DHE;
        done = 1;
      end else begin
        if (dk == DK_EP) errf = 1;
        if (st_q.size() > 0) sk = st_q.pop_front();
        else begin
          r = $urandom % 100;
          sk = (r < 70) ? SK_OK : (r < 90) ? SK_ERR
             : (r < 95) ? SK_OTH : SK_TMO;
        end
        word = (sk == SK_OK) ? R_OK : (sk == SK_ERR) ? R_ERR
             : ($urandom | 32'h100);
        do_sts(sk, word);
        if (sk != SK_TMO) nw++;
        case (sk)
          SK_OK: begin
            rem -= flen; frm++; retry = 0; sexp = R_OK;
            if (last || errf) done = 1;
          end
          SK_ERR: begin
            sexp = R_ERR;
            if (retry < MAXR && !errf) retry++;
            else done = 1;
          end
          SK_OTH: begin sexp = word; done = 1; end
          default: begin sexp = S_TMO; done = 1; end
        endcase
      end
    end
    n = 0;
    while (!bail && !u.txdma2port_ack && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (!bail) begin
      checks++;
      if (n == 40) begin
        errors++;
        $display("FAIL done_wait got timeout exp ack");
      end
      checks++;
      if (u.txdma2port_sts !== sexp) begin
        errors++;
        $display("FAIL sts got %h exp %h", u.txdma2port_sts, sexp);
      end
      checks++;
      if (u.txdma2port_frm_cnt !== 16'(frm)) begin
        errors++;
        $display("FAIL frm_cnt got %0d exp %0d",
                 u.txdma2port_frm_cnt, frm);
      end
      u.port2txdma_req = 0;
      @(negedge sys_clk);
      checks++;
      if (dst_tot - d0 !== nw) begin
        errors++;
        $display("FAIL dst_pulses got %0d exp %0d", dst_tot - d0, nw);
      end
      checks++;
      if (u.txdma2port_idle !== 1'b1) begin
        errors++;
        $display("FAIL idle_after got %b exp 1", u.txdma2port_idle);
      end
    end else recover();
  endtask

  task automatic test_reset();
    checks++;
    if (u.txdma2port_idle !== 1'b1 || u.txdma2port_ack !== 1'b0 ||
        u.tx2dh_req !== 1'b0 || u.ctrl_dst_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b%b%b%b exp 1000", u.txdma2port_idle,
               u.txdma2port_ack, u.tx2dh_req, u.ctrl_dst_rdy);
    end
    checks++;
    if (u.txdma2port_sts !== 32'h0 || u.txdma2port_frm_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rst_sts got %h/%h exp 0/0",
               u.txdma2port_sts, u.txdma2port_frm_cnt);
    end
    checks++;
    if (u.txdma2dbg !== 32'h0000_0400) begin
      errors++;
      $display("FAIL rst_dbg got %h exp 00000400", u.txdma2dbg);
    end
  endtask

  task automatic test_directed();
    repeat (3) begin dh_q.push_back(DK_ACK); st_q.push_back(SK_OK); end
    run_xfer(32'h5000);
    dh_q.push_back(DK_ACK); st_q.push_back(SK_OK);
    run_xfer(32'h0);
    repeat (5) dh_q.push_back(DK_ACK);
    st_q.push_back(SK_OK);
    repeat (4) st_q.push_back(SK_ERR);
    run_xfer(32'h3000);
    dh_q.push_back(DK_NP);
    run_xfer(32'h3000);
    dh_q.push_back(DK_EP); st_q.push_back(SK_OK);
    run_xfer(32'h5000);
  endtask

  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      u.port2txdma_len = 32'h1000;
      u.port2txdma_req = 1;
      do_dh(32'h1000, DK_ACK);
      if (bail) begin recover(); continue; end
      repeat (15) @(negedge sys_clk);
      checks++;
      if (u.txdma2port_ack !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early v%0d got %b exp 0", v, u.txdma2port_ack);
      end
      if (v == 1) begin
        u.ctrl_src_rdy_n = 0;
        u.ctrl_data = R_OK;
      end
      @(negedge sys_clk);
      u.ctrl_src_rdy_n = 1;
      checks++;
      if (u.txdma2port_ack !== 1'b1 ||
          u.txdma2port_sts !== ((v == 1) ? R_OK : S_TMO) ||
          u.ctrl_dst_rdy !== 1'(v)) begin
        errors++;
        $display("FAIL tmo_edge v%0d got %b/%h/%b exp 1/%h/%0d", v,
                 u.txdma2port_ack, u.txdma2port_sts, u.ctrl_dst_rdy,
                 (v == 1) ? R_OK : S_TMO, v);
      end
      u.port2txdma_req = 0;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    u.port2txdma_len = 32'h4000;
    u.port2txdma_req = 1;
    while (!u.tx2dh_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    u.port2txdma_abort = 1;
    @(negedge sys_clk);
    u.port2txdma_abort = 0;
    checks++;
    if (u.tx2dh_req !== 1'b0 || u.txdma2port_ack !== 1'b1 ||
        u.txdma2port_sts !== S_ABT) begin
      errors++;
      $display("FAIL abort got %b/%b/%h exp 0/1/%h", u.tx2dh_req,
               u.txdma2port_ack, u.txdma2port_sts, S_ABT);
    end
    u.port2txdma_req = 0;
    @(negedge sys_clk);
    checks++;
    if (u.txdma2port_idle !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got %b exp 1", u.txdma2port_idle);
    end
  endtask

  task automatic test_reset_mid_sts();
    u.port2txdma_len = 32'h3000;
    u.port2txdma_req = 1;
    do_dh(32'h2000, DK_ACK);
    do_sts(SK_OK, R_OK);
    do_dh(32'h1000, DK_ACK);
    #1;
    sys_rst_n = 0;
    #1;
    checks++;
    if (u.txdma2port_idle !== 1'b1 || u.tx2dh_req !== 1'b0 ||
        u.txdma2port_sts !== 32'h0 || u.txdma2port_frm_cnt !== 16'h0 ||
        u.txdma2dbg !== 32'h0000_0400) begin
      errors++;
      $display("FAIL rst_mid got %b/%b/%h/%h/%h exp 1/0/0/0/400",
               u.txdma2port_idle, u.tx2dh_req, u.txdma2port_sts,
               u.txdma2port_frm_cnt, u.txdma2dbg);
    end
    recover();
  endtask

  task automatic test_random();
    logic [31:0] len;
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 32'h7000);
      if ($urandom % 8 == 0) len = 0;
      else if ($urandom % 8 == 0) len = 32'h2000 * $urandom_range(1, 3);
      run_xfer(len);
    end
  endtask

  initial begin
    u.port2txdma_req = 0;
    u.port2txdma_len = 0;
    u.port2txdma_abort = 0;
    u.dh2tx_ack = 0;
    u.dh2tx_err = 0;
    u.ctrl_src_rdy_n = 1;
    u.ctrl_data = 0;
    u.txdma2txll_push = 0;
    repeat (3) @(negedge sys_clk);
    test_reset();
    sys_rst_n = 1;
    @(negedge sys_clk);
    test_reset();
    test_directed();
    test_timeout();
    test_abort();
    test_reset_mid_sts();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
